// File: rtl/pong_pkg.sv
// Shared pong definitions: game state encoding, winner codes and default grid constants.
// Used by the game controller, ball, paddle and score-overlay blocks.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RUNNING   = 3'd1,
      ST_POINT     = 3'd2,
      ST_PAUSE     = 3'd3,
      ST_GAME_OVER = 3'd4
   } game_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   localparam int unsigned GAME_WIDTH_DEF    = 40;
   localparam int unsigned GAME_HEIGHT_DEF   = 30;
   localparam int unsigned PADDLE_HEIGHT_DEF = 6;
   localparam int unsigned PADDLE_COL_P1_DEF = 0;
   localparam int unsigned PADDLE_COL_P2_DEF = 39;
   localparam int unsigned SCORE_LIMIT_DEF   = 9;
   localparam int unsigned PAUSE_FRAMES_DEF  = 60;

endpackage

// File: rtl/pong_game_ctrl_frame_pause_timer.sv
// Counts frame ticks while enabled; odone is high on the tick that completes N frames,
// so the caller can leave its pause state on that same edge.
module frame_pause_timer #(
   parameter int unsigned N = 60
) (
   input  logic clock,
   input  logic reset_n,
   input  logic iclear,
   input  logic ienable,
   input  logic iframe_tick,
   output logic odone
);

   logic [7:0] r_count;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_count <= 8'd0;
      end else if (iclear) begin
         r_count <= 8'd0;
      end else if (ienable && iframe_tick) begin
         r_count <= r_count + 8'd1;
      end
   end

   assign odone = ienable && iframe_tick && (r_count == 8'(N - 1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: miss detection at both edges, score keeping, serve pause and game over.
// All outputs registered; a miss shows as POINT one cycle later and as a score two cycles later.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned GAME_WIDTH    = GAME_WIDTH_DEF,
   parameter int unsigned GAME_HEIGHT   = GAME_HEIGHT_DEF,
   parameter int unsigned PADDLE_HEIGHT = PADDLE_HEIGHT_DEF,
   parameter int unsigned PADDLE_COL_P1 = PADDLE_COL_P1_DEF,
   parameter int unsigned PADDLE_COL_P2 = PADDLE_COL_P2_DEF,
   parameter int unsigned SCORE_LIMIT   = SCORE_LIMIT_DEF,
   parameter int unsigned PAUSE_FRAMES  = PAUSE_FRAMES_DEF
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       istart,
   input  logic       iframe_tick,
   input  logic [5:0] iballx,
   input  logic [5:0] ibally,
   input  logic [5:0] ip1y,
   input  logic [5:0] ip2y,
   output logic       ogame_active,
   output logic [3:0] op1_score,
   output logic [3:0] op2_score,
   output logic [1:0] owinner,
   output logic [2:0] ostate
);

   // A right paddle column that is not the last grid column falls back to the grid edge.
   localparam bit          GRID_OK   = (PADDLE_COL_P2 == GAME_WIDTH - 1) && (PADDLE_HEIGHT <= GAME_HEIGHT);
   localparam int unsigned RIGHT_COL = GRID_OK ? PADDLE_COL_P2 : GAME_WIDTH - 1;

   game_state_t r_state;
   logic        r_active;
   logic [3:0]  r_p1_score;
   logic [3:0]  r_p2_score;
   logic [1:0]  r_winner;
   logic        r_start_d;
   logic        r_p2_scored;

   logic [6:0]  w_p1_bot;
   logic [6:0]  w_p2_bot;
   logic        w_miss_p1;
   logic        w_miss_p2;
   logic [3:0]  w_p1_inc;
   logic [3:0]  w_p2_inc;
   logic        w_pause_done;

   // Paddle bottoms are 7 bits wide so a paddle near row 63 cannot wrap to the top.
   assign w_p1_bot  = {1'b0, ip1y} + 7'(PADDLE_HEIGHT);
   assign w_p2_bot  = {1'b0, ip2y} + 7'(PADDLE_HEIGHT);
   assign w_miss_p1 = (iballx == 6'(PADDLE_COL_P1)) &&
                      ((ibally < ip1y) || ({1'b0, ibally} >= w_p1_bot));
   assign w_miss_p2 = (iballx == 6'(RIGHT_COL)) &&
                      ((ibally < ip2y) || ({1'b0, ibally} >= w_p2_bot));

   assign w_p1_inc = (r_p1_score == 4'hF) ? 4'hF : r_p1_score + 4'd1;
   assign w_p2_inc = (r_p2_score == 4'hF) ? 4'hF : r_p2_score + 4'd1;

   frame_pause_timer #(
      .N (PAUSE_FRAMES)
   ) u_pause_timer (
      .clock       (clock),
      .reset_n     (reset_n),
      .iclear      (r_state == ST_POINT),
      .ienable     (r_state == ST_PAUSE),
      .iframe_tick (iframe_tick),
      .odone       (w_pause_done)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_active    <= 1'b0;
         r_p1_score  <= 4'd0;
         r_p2_score  <= 4'd0;
         r_winner    <= WIN_NONE;
         r_start_d   <= 1'b0;
         r_p2_scored <= 1'b0;
      end else begin
         r_start_d <= istart;
         case (r_state)
            ST_IDLE: begin
               if (istart) begin
                  r_state  <= ST_RUNNING;
                  r_active <= 1'b1;
               end
            end
            ST_RUNNING: begin
               // Left edge wins if both edges ever report a miss together.
               if (w_miss_p1 || w_miss_p2) begin
                  r_state     <= ST_POINT;
                  r_active    <= 1'b0;
                  r_p2_scored <= w_miss_p1;
               end
            end
            ST_POINT: begin
               if (r_p2_scored) begin
                  r_p2_score <= w_p2_inc;
                  if (w_p2_inc == 4'(SCORE_LIMIT)) begin
                     r_state  <= ST_GAME_OVER;
                     r_winner <= WIN_P2;
                  end else begin
                     r_state <= ST_PAUSE;
                  end
               end else begin
                  r_p1_score <= w_p1_inc;
                  if (w_p1_inc == 4'(SCORE_LIMIT)) begin
                     r_state  <= ST_GAME_OVER;
                     r_winner <= WIN_P1;
                  end else begin
                     r_state <= ST_PAUSE;
                  end
               end
            end
            ST_PAUSE: begin
               if (w_pause_done) begin
                  r_state  <= ST_RUNNING;
                  r_active <= 1'b1;
               end
            end
            ST_GAME_OVER: begin
               if (istart && !r_start_d) begin
                  r_state    <= ST_IDLE;
                  r_p1_score <= 4'd0;
                  r_p2_score <= 4'd0;
                  r_winner   <= WIN_NONE;
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign ogame_active = r_active;
   assign op1_score    = r_p1_score;
   assign op2_score    = r_p2_score;
   assign owinner      = r_winner;
   assign ostate       = r_state;

endmodule
